// File: rtl/screen_painter.sv
// Full-frame painter: walks every pixel in raster order, issues linear ROM addresses,
// and re-aligns the selected ROM colour with its coordinates for the vga_adapter.
module screen_painter #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int ADDR_W      = 15,
  parameter int COLOR_W     = 3,
  parameter int NUM_SCREENS = 4,
  parameter int SEL_W       = 2,
  parameter int ROM_LATENCY = 1
) (
  input  logic                           CLOCK_50,
  input  logic                           RESETN,
  input  logic [SEL_W-1:0]               SCREEN,
  input  logic                           REDRAW,
  input  logic                           ENABLE,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [NUM_SCREENS*COLOR_W-1:0] rom_q,
  output logic [X_W-1:0]                 x,
  output logic [Y_W-1:0]                 y,
  output logic [COLOR_W-1:0]             colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           frame_done
);

  typedef enum logic [1:0] {START, SCAN, DRAIN, HOLD} state_e;

  typedef struct packed {
    logic             v;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [SEL_W-1:0] sel;
  } stage_t;

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [X_W-1:0]    ix_q;
  logic [Y_W-1:0]    iy_q;
  logic [ADDR_W-1:0] addr_q;
  stage_t            pipe_q [ROM_LATENCY];

  stage_t            tail_s;
  logic              restart_s;
  logic              abort_s;
  logic              issue_s;
  logic              last_x_s;
  logic              last_s;
  logic              pipe_busy_s;
  logic              out_valid_s;
  logic [COLOR_W-1:0] pix_col_s;

  assign rom_addr    = addr_q;
  assign tail_s      = pipe_q[ROM_LATENCY-1];
  assign restart_s   = (SCREEN != sel_q) || REDRAW;
  assign abort_s     = ((state_q == SCAN) || (state_q == DRAIN)) && restart_s;
  assign issue_s     = (state_q == SCAN) && ENABLE && !restart_s;
  assign last_x_s    = (ix_q == X_W'(H_RES - 1));
  assign last_s      = last_x_s && (iy_q == Y_W'(V_RES - 1));
  assign out_valid_s = tail_s.v && !abort_s;

  // Pipeline occupancy, used to decide when the drain is complete.
  always_comb begin
    pipe_busy_s = 1'b0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      pipe_busy_s = pipe_busy_s | pipe_q[i].v;
    end
  end

  // Pick the colour slice of the screen carried with the pixel; unmapped screens give 0.
  always_comb begin
    pix_col_s = '0;
    for (int k = 0; k < NUM_SCREENS; k++) begin
      pix_col_s = (int'(tail_s.sel) == k) ? rom_q[k*COLOR_W +: COLOR_W] : pix_col_s;
    end
  end

  // Frame sequencer: issue counters, incremental address and busy flag.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= START;
      sel_q   <= '0;
      ix_q    <= '0;
      iy_q    <= '0;
      addr_q  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        START: begin
          sel_q   <= SCREEN;
          ix_q    <= '0;
          iy_q    <= '0;
          addr_q  <= '0;
          busy    <= 1'b1;
          state_q <= SCAN;
        end
        SCAN: begin
          if (restart_s) begin
            state_q <= START;
          end else if (issue_s) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (last_x_s) begin
              ix_q <= '0;
              iy_q <= iy_q + Y_W'(1);
            end else begin
              ix_q <= ix_q + X_W'(1);
            end
            if (last_s) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (restart_s) begin
            state_q <= START;
          end else if (!pipe_busy_s) begin
            state_q <= HOLD;
            busy    <= 1'b0;
          end
        end
        HOLD: begin
          busy <= 1'b0;
          if (restart_s) begin
            state_q <= START;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

  // Coordinate pipeline matching the ROM latency, followed by the registered plot stage.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pipe_q[0] <= '{v: issue_s, x: ix_q, y: iy_q, sel: sel_q};
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      // An abort kills everything in flight so no stale pixel reaches the screen.
      if (abort_s) begin
        for (int i = 0; i < ROM_LATENCY; i++) begin
          pipe_q[i].v <= 1'b0;
        end
      end
      plot       <= out_valid_s;
      frame_done <= out_valid_s && (tail_s.x == X_W'(H_RES - 1)) && (tail_s.y == Y_W'(V_RES - 1));
      if (out_valid_s) begin
        x      <= tail_s.x;
        y      <= tail_s.y;
        colour <= pix_col_s;
      end
    end
  end

endmodule

// File: tb/tb_screen_painter.sv
// Bench for screen_painter: a full-size instance (latency 1, four screens) and a small-frame
// instance (latency 3, three screens), each checked against a raster-order pixel model.
module tb_screen_painter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic [1:0]  scr_a = 2'd1, scr_b = 2'd1;
  logic        redraw_a = 1'b0, redraw_b = 1'b0;
  logic        en_a = 1'b1, en_b = 1'b1;
  logic [14:0] rom_addr_a, rom_addr_b;
  logic [11:0] rom_q_a;
  logic [8:0]  rom_q_b;
  logic [1:0]       plot_m, busy_m, fd_m;
  logic [1:0][7:0]  x_m;
  logic [1:0][6:0]  y_m;
  logic [1:0][2:0]  col_m;

  int errors = 0;
  int checks = 0;

  int    hres[2]  = '{160, 24};
  int    npix[2]  = '{19200, 240};
  int    ns[2]    = '{4, 3};
  string tagn[2]  = '{"pixA", "pixB"};
  int exp_idx[2]  = '{0, 0};
  int plots[2]    = '{0, 0};
  int fd_cnt[2]   = '{0, 0};
  int first_cyc[2] = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int start_cyc[2] = '{0, 0};
  int abort_cyc[2] = '{0, 0};
  int req[2]      = '{0, 0};
  int ack[2]      = '{0, 0};
  logic [1:0] sel_req[2] = '{2'd1, 2'd1};
  logic [1:0] exp_sel[2] = '{2'd1, 2'd1};

  screen_painter dut_a (
    .CLOCK_50(clk), .RESETN(rst_a), .SCREEN(scr_a), .REDRAW(redraw_a), .ENABLE(en_a),
    .rom_addr(rom_addr_a), .rom_q(rom_q_a), .x(x_m[0]), .y(y_m[0]), .colour(col_m[0]),
    .plot(plot_m[0]), .busy(busy_m[0]), .frame_done(fd_m[0])
  );

  screen_painter #(.H_RES(24), .V_RES(10), .NUM_SCREENS(3), .ROM_LATENCY(3)) dut_b (
    .CLOCK_50(clk), .RESETN(rst_b), .SCREEN(scr_b), .REDRAW(redraw_b), .ENABLE(en_b),
    .rom_addr(rom_addr_b), .rom_q(rom_q_b), .x(x_m[1]), .y(y_m[1]), .colour(col_m[1]),
    .plot(plot_m[1]), .busy(busy_m[1]), .frame_done(fd_m[1])
  );

  // Image contents: screen 1 is addr[2:0], the others are distinct XOR patterns.
  function automatic logic [2:0] rom_val(input logic [1:0] k, input logic [14:0] a);
    case (k)
      2'd0:    return ~a[2:0];
      2'd1:    return a[2:0];
      2'd2:    return a[2:0] ^ 3'b101;
      default: return a[2:0] ^ 3'b010;
    endcase
  endfunction

  // Synchronous ROMs with one and three cycles of read latency.
  logic [14:0] a_d1;
  logic [14:0] b_d [3];
  always @(posedge clk) begin
    a_d1   <= rom_addr_a;
    b_d[0] <= rom_addr_b;
    b_d[1] <= b_d[0];
    b_d[2] <= b_d[1];
  end
  assign rom_q_a = {rom_val(2'd3, a_d1), rom_val(2'd2, a_d1), rom_val(2'd1, a_d1), rom_val(2'd0, a_d1)};
  assign rom_q_b = {rom_val(2'd2, b_d[2]), rom_val(2'd1, b_d[2]), rom_val(2'd0, b_d[2])};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Raster-order model: every plot must be the next pixel of the current frame.
  initial begin
    int p, ex, ey;
    logic [2:0] ec;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (plot_m[g]) begin
          p  = exp_idx[g];
          ex = p % hres[g];
          ey = p / hres[g];
          ec = (int'(exp_sel[g]) < ns[g]) ? rom_val(exp_sel[g], p[14:0]) : 3'd0;
          chk(tagn[g], {12'd0, busy_m[g], fd_m[g], x_m[g], y_m[g], col_m[g]},
              {12'd0, 1'b1, (p == npix[g] - 1), ex[7:0], ey[6:0], ec});
          if (p == 0) first_cyc[g] = cyc;
          if (p == npix[g] - 1) begin
            fd_cnt[g]++;
            done_cyc[g] = cyc;
          end
          exp_idx[g]++;
          plots[g]++;
        end else if (fd_m[g]) begin
          chk("fd_without_plot", 32'd1, 32'd0);
        end
        if (req[g] != ack[g]) begin
          ack[g]     = req[g];
          exp_idx[g] = 0;
          plots[g]   = 0;
          exp_sel[g] = sel_req[g];
        end
      end
    end
  end

  task automatic set_en(input int g, input logic v);
    if (g == 0) en_a = v;
    else en_b = v;
  endtask

  task automatic restart(input int g, input logic [1:0] s, input logic rd);
    if (g == 0) begin scr_a = s; redraw_a = rd; end
    else begin scr_b = s; redraw_b = rd; end
    sel_req[g]   = s;
    req[g]++;
    abort_cyc[g] = cyc;
    @(posedge clk); #1;
    if (g == 0) redraw_a = 1'b0;
    else redraw_b = 1'b0;
  endtask

  // mode 0: ENABLE high; 1: low 10 of every 100 cycles; 2: random ENABLE.
  task automatic run(input int g, input int mode, input int stop_at, input int budget);
    int fd0, k;
    bit done;
    fd0 = fd_cnt[g]; k = 0; done = 1'b0;
    while (!done && k < budget) begin
      case (mode)
        1:       set_en(g, (k % 100) < 90);
        2:       set_en(g, $urandom_range(0, 3) != 0);
        default: set_en(g, 1'b1);
      endcase
      @(posedge clk); #1;
      k++;
      done = (stop_at > 0) ? (plots[g] >= stop_at) : (fd_cnt[g] != fd0);
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    set_en(g, 1'b1);
  endtask

  task automatic frame_checks(input int g, input int fd0, input int lat, input int ref_cyc, input bit contig);
    chk("frame_plots", plots[g], npix[g]);
    chk("frame_done_once", fd_cnt[g] - fd0, 32'd1);
    if (lat >= 0) chk("first_plot_latency", first_cyc[g] - ref_cyc, lat);
    if (contig) chk("back_to_back", done_cyc[g] - first_cyc[g], npix[g] - 1);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", busy_m[g], 32'd0);
    chk("idle_no_plots", plots[g], npix[g]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_a", rom_addr_a, 32'd0);
    chk("rst_out_a", {x_m[0], y_m[0], col_m[0], plot_m[0], busy_m[0], fd_m[0]}, 32'd0);
    chk("rst_out_b", {x_m[1], y_m[1], col_m[1], plot_m[1], busy_m[1], fd_m[1]}, 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_cyc[0] = cyc;
    start_cyc[1] = cyc;
    fork
      begin : thread_a
        int fd0;
        repeat (160) @(posedge clk);
        @(negedge clk);
        chk("wrap_addr_159", rom_addr_a, 32'd159);
        @(negedge clk);
        chk("wrap_addr_160", rom_addr_a, 32'd160);
        run(0, 0, 0, 25000);
        frame_checks(0, 0, 3, start_cyc[0], 1'b1);
        restart(0, 2'd0, 1'b0);
        run(0, 0, $urandom_range(4990, 5010), 6000);
        fd0 = fd_cnt[0];
        restart(0, 2'd2, 1'b0);
        run(0, 0, 0, 25000);
        frame_checks(0, fd0, 4, abort_cyc[0], 1'b1);
        fd0 = fd_cnt[0];
        restart(0, 2'd2, 1'b1);
        run(0, 1, 0, 25000);
        frame_checks(0, fd0, -1, 0, 1'b0);
      end
      begin : thread_b
        int fd0;
        run(1, 0, 0, 2000);
        frame_checks(1, 0, 5, start_cyc[1], 1'b1);
        fd0 = fd_cnt[1];
        restart(1, 2'd3, 1'b0);
        run(1, 0, 0, 2000);
        frame_checks(1, fd0, 6, abort_cyc[1], 1'b1);
        for (int r = 0; r < 3; r++) begin
          restart(1, 2'($urandom_range(0, 3)), 1'b1);
          run(1, 2, $urandom_range(20, 200), 3000);
          fd0 = fd_cnt[1];
          restart(1, 2'($urandom_range(0, 3)), 1'b1);
          run(1, 2, 0, 3000);
          frame_checks(1, fd0, -1, 0, 1'b0);
        end
        restart(1, sel_req[1], 1'b1);
        run(1, 0, $urandom_range(20, 200), 2000);
        fd0 = fd_cnt[1];
        #1 rst_b = 1'b0;
        req[1]++;
        #1;
        chk("async_rst_out", {x_m[1], y_m[1], col_m[1], plot_m[1], busy_m[1], fd_m[1]}, 32'd0);
        chk("async_rst_addr", rom_addr_b, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        start_cyc[1] = cyc;
        run(1, 0, 0, 2000);
        frame_checks(1, fd0, 5, start_cyc[1], 1'b1);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_painter.md
Name: screen_painter

Overview:
- Full-frame painter that replaces free-running x/y plotting: walks every pixel of the frame, issues linear ROM addresses, and aligns the returned ROM data with its coordinates.
- Selects one of NUM_SCREENS image ROMs using the screen code from the game display FSM.
- Drives x/y/colour/plot of the vga_adapter. Repaints automatically when the screen code changes or on a redraw request.

Parameters:
- H_RES, 160, pixels per row
- V_RES, 120, rows per frame
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- COLOR_W, 3, colour bits per pixel (3 * bits per channel)
- NUM_SCREENS, 4, number of image ROMs
- SEL_W, 2, screen select width
- ROM_LATENCY, 1, ROM read latency in cycles (>=1)

Ports:
- CLOCK_50  in  1  system clock
- RESETN  in  1  asynchronous active-low reset
- SCREEN  in  SEL_W  screen code from the display FSM
- REDRAW  in  1  single-cycle request to repaint the current screen
- ENABLE  in  1  scan advance enable; low stalls address issue
- rom_addr  out  ADDR_W  shared address to all image ROMs
- rom_q  in  NUM_SCREENS*COLOR_W  concatenated ROM outputs; screen k occupies bits [k*COLOR_W +: COLOR_W]
- x  out  X_W  pixel x to vga_adapter
- y  out  Y_W  pixel y to vga_adapter
- colour  out  COLOR_W  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter
- busy  out  1  frame paint in progress
- frame_done  out  1  one-cycle pulse on the final plot of a frame

Behaviour:
- Reset (async, RESETN=0) sets:
  - rom_addr=0, x=0, y=0, colour=0, plot=0, busy=0, frame_done=0
  - all pipeline valid bits = 0
  - state = START
- States:
  - START: one cycle. Latch sel_q <= SCREEN. Clear issue counters (ix=0, iy=0, addr=0). busy <= 1. Go to SCAN.
  - SCAN: each cycle with ENABLE=1, issue pixel (ix, iy) at rom_addr = addr.
    - Then ix++, addr++.
    - At ix = H_RES-1: ix <= 0, iy++.
    - Issue of (H_RES-1, V_RES-1) moves the state to DRAIN.
    - ENABLE=0: no issue; counters and rom_addr hold.
  - DRAIN: issue nothing. Wait until the pipeline is empty, then go to HOLD.
  - HOLD: busy=0. Go to START when SCREEN != sel_q or REDRAW=1.
- Address is maintained incrementally and must always equal iy*H_RES + ix. No multiplier.
- Pipeline:
  - Pixel issued in cycle t carries {valid, ix, iy, sel_q} through ROM_LATENCY+1 register stages.
  - rom_q is valid in cycle t+ROM_LATENCY.
  - x, y, colour and plot=1 are registered outputs, valid in cycle t+ROM_LATENCY+1.
  - Latency from issue to plot = ROM_LATENCY+1 cycles.
  - The pipeline keeps shifting while ENABLE=0. Stalls insert plot=0 bubbles; no pixel is lost or duplicated.
- colour = rom_q slice selected by the sel carried with that pixel. A sel >= NUM_SCREENS gives colour=0, and the pixel is still plotted.
- plot=0 on every cycle without a valid pipeline output. On those cycles x, y and colour hold their last values.
- frame_done = 1 exactly in the cycle plot=1 for (H_RES-1, V_RES-1).
- busy is high from the cycle after START through the frame_done cycle inclusive.
- Interruptions:
  - SCREEN change or REDRAW during SCAN or DRAIN aborts the frame. Next cycle is START. All in-flight valid bits are cleared, so no pixel from the old frame is plotted after the abort cycle.
  - No frame_done is generated for an aborted frame.
  - SCREEN change and REDRAW in the same cycle are treated as one restart.
- Reset mid-scan: outputs go to reset values immediately. A full repaint starts after release.
- Frame length with ENABLE held high: START (1) + H_RES*V_RES issue cycles + drain. First plot occurs ROM_LATENCY+2 cycles after START.

Test Plan:
- Reset release, SCREEN=1, ENABLE=1, ROM_LATENCY=1, ROM model returning addr[2:0] → exactly 19200 plot pulses in 19200 consecutive cycles.
  - First plot at x=0, y=0, colour=0, 3 cycles after START.
  - frame_done once with x=159, y=119.
  - busy low afterwards, no further plots.
- Row wrap check → rom_addr 159 then 160 while issuing (159,0) then (0,1). Plotted colours match addr[2:0] of the matching address: 7, then 0.
- SCREEN changes 0→2 at pixel 5000 → no old-screen plot after the abort cycle, no frame_done for the aborted frame. New frame restarts at (0,0) using the screen-2 slice and completes 19200 plots.
- ENABLE toggled low for 10 cycles every 100 cycles → still exactly 19200 plots, in raster order, none duplicated; frame_done once.
- SCREEN=3 with NUM_SCREENS=3 → every plotted colour = 0; full frame still plotted.
- RESETN pulsed low mid-frame → plot=0, x=0, y=0, busy=0 asynchronously. Fresh full frame after release.
- Rerun the first scenario with ROM_LATENCY=3 → first plot 5 cycles after START; coordinate and colour alignment still exact.
